layer_sequencer: RTL
====================

# layer_sequencer

Per-layer neuron sequencer and output collector for the MLP datapath, sitting directly downstream of `DotProduct`. It restarts `DotProduct` once per neuron via that module's reset input and presents the current neuron index so upstream weight muxing selects the matching row. It captures each IEEE-754 single-precision result on `endf`, applies optional ReLU, and assembles an N-word output vector for the next layer.

## Interface
- `N`, default 10: neurons per layer, i.e. number of dot products per run (≥1).
- `RELU`, default 1: 1 = apply ReLU on capture; 0 = store raw result.
- `RST_CYC`, default 2: cycles `dp_reset` is held high per neuron (≥1).
- `TIMEOUT`, default 4096: max WAIT cycles without `endf` before abort.
- `CLK`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a layer run when idle.
- `dp_result`  in  32  float32 result from `DotProduct`.
- `dp_endf`  in  1  `DotProduct` end flag; treated as a level.
- `dp_reset`  out  1  drives `DotProduct` reset.
- `neuron_idx`  out  $clog2(N) (min 1)  row currently being computed.
- `out_vec`  out  32*N  collected outputs; word i at bits [32*i+31:32*i].
- `busy`  out  1  high from the cycle after accepted `start` until DONE or abort.
- `done`  out  1  one-cycle pulse when all N words are stored.
- `error`  out  1  sticky timeout flag.

## Operation
- Reset values: state IDLE, `dp_reset`=1, `neuron_idx`=0, `out_vec`=0, `busy`=0, `done`=0, `error`=0.
- IDLE: `dp_reset`=1. `start` → CLEAR, `neuron_idx`←0, `error`←0, `busy`←1. `out_vec` is not cleared on start and keeps its old contents until overwritten word by word.
- CLEAR: `dp_reset`=1 for exactly RST_CYC cycles (counter), then → BLANK. `dp_endf` is ignored.
- BLANK: `dp_reset`=0 for one cycle, with `dp_endf` ignored (stale-flag guard), then → WAIT.
- WAIT: `dp_reset`=0, timeout counter running.
  - `dp_endf`=1 → STORE.
  - Counter reaching TIMEOUT → IDLE with `error`←1, `busy`←0, no `done`.
- STORE: write the processed `dp_result` into word `neuron_idx`.
  - If `neuron_idx`==N-1 → DONE.
  - Else `neuron_idx`+1 → CLEAR.
- DONE: `done`=1 for one cycle, `busy`←0, `dp_reset`←1, → IDLE. `neuron_idx` holds N-1 until the next start.
- ReLU (RELU=1):
  - Sign bit 1 stores 32'h0000_0000. This covers negatives, -0 and -NaN.
  - Otherwise the value is stored unchanged, including +Inf and +NaN.
- RELU=0: bit-exact pass-through.
- `start` while `busy`, or during DONE, is ignored.
- `reset` asserted mid-run takes priority over every transition: next cycle is IDLE with all reset values, including `out_vec` cleared.
- `dp_result` is sampled in the STORE cycle. `DotProduct` holds its result while `endf` is high, so no extra register is needed.

## Timing
- Accepted `start` at edge t: CLEAR occupies t+1..t+RST_CYC, BLANK is at t+RST_CYC+1, and WAIT begins at t+RST_CYC+2.
- `dp_endf` first seen high in WAIT at cycle w: STORE at w+1, and the word is visible on `out_vec` from w+2.
- Per-neuron overhead beyond `DotProduct` latency: RST_CYC+3 cycles.
- `done` is high in the cycle after the last word is written, and the last word is already visible that cycle.
- `neuron_idx` is stable from CLEAR entry through STORE of the same neuron. Upstream may register-select weights during CLEAR.
- Timeout: abort occurs on the TIMEOUT-th WAIT cycle with no `endf`. `error` goes high the following cycle.

## Test plan
- N=3, RELU=1, DotProduct model returning 3F80_0000, C000_0000, 4040_0000 → `out_vec` = {4040_0000, 0000_0000, 3F80_0000}, one `done` pulse, `busy` low after it.
- RELU=0, same stimulus → word 1 = C000_0000. Inputs 8000_0000 and FFC0_0000 are stored unchanged; with RELU=1 both store 0000_0000.
- RST_CYC=2: `dp_reset` high exactly 2 cycles per neuron. A `dp_endf` held high during CLEAR and BLANK is not captured, and `neuron_idx` steps 0→1→2.
- TIMEOUT=16, `dp_endf` never asserted → `error`=1 after 16 WAIT cycles, `busy`=0, no `done`. The next `start` clears `error`.
- `reset` pulsed during WAIT of neuron 1 → next cycle IDLE, `out_vec`=0, `dp_reset`=1. A fresh `start` then completes normally.
- `start` pulsed again mid-run and during DONE → ignored: no restart, `neuron_idx` is unaffected, and exactly one `done` pulse occurs.

Source files
------------

// File: rtl/layer_sequencer.sv
// layer_sequencer: restarts DotProduct once per neuron, captures each float32
// result (optionally through ReLU) and collects N words into out_vec.
module layer_sequencer #(
    parameter int N       = 10,
    parameter int RELU    = 1,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 4096,
    localparam int NW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            start,
    input  logic [31:0]     dp_result,
    input  logic            dp_endf,
    output logic            dp_reset,
    output logic [NW-1:0]   neuron_idx,
    output logic [32*N-1:0] out_vec,
    output logic            busy,
    output logic            done,
    output logic            error
);

    // One counter serves both the CLEAR hold time and the WAIT timeout.
    localparam int CMAX = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [NW-1:0] IDX_LAST = NW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_BLANK = 3'd2,
        S_WAIT  = 3'd3,
        S_STORE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NW-1:0]     idx_q, idx_d;
    logic [32*N-1:0]   out_vec_q, out_vec_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;

    // Negative sign (including -0 and -NaN) clamps to +0; everything else passes.
    function automatic logic [31:0] relu_f(input logic [31:0] x);
        if (RELU != 0 && x[31]) return 32'h0000_0000;
        return x;
    endfunction

    // Next-state and datapath update for the per-neuron sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        out_vec_d = out_vec_q;
        busy_d    = busy_q;
        error_d   = error_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    idx_d   = '0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_CLEAR: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BLANK: begin
                // A flag left over from the previous neuron is not trusted here.
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (dp_endf) begin
                    state_d = S_STORE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STORE: begin
                // DotProduct holds its result while endf is high, so sample directly.
                for (int i = 0; i < N; i++) begin
                    if (idx_q == NW'(i)) out_vec_d[32*i +: 32] = relu_f(dp_result);
                end
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + NW'(1);
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and data registers; reset returns everything, including out_vec, to zero.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            out_vec_q <= '0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            out_vec_q <= out_vec_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
        end
    end

    // DotProduct is held in reset everywhere except BLANK, WAIT and STORE.
    always_comb begin
        dp_reset = (state_q == S_IDLE) || (state_q == S_CLEAR) || (state_q == S_DONE);
    end

    assign neuron_idx = idx_q;
    assign out_vec    = out_vec_q;
    assign busy       = busy_q;
    assign done       = (state_q == S_DONE);
    assign error      = error_q;

endmodule
